// File: rtl/imm_unit_if.sv
// Handshake bundle between the instruction producer and the immediate unit.
// The master drives instructions in and accepts results; the slave is the unit.
interface imm_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      immsrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immext;
    logic [2:0]      fmt;
    logic            illegal;
    logic [15:0]     err_count;

    modport master (
        output in_valid, instr, immsrc, out_ready,
        input  in_ready, out_valid, immext, fmt, illegal, err_count
    );

    modport slave (
        input  in_valid, instr, immsrc, out_ready,
        output in_ready, out_valid, immext, fmt, illegal, err_count
    );
endinterface

// File: rtl/imm_unit.sv
// Decode-stage immediate generator: picks the immediate format, extends it to
// XLEN and hands results out through a 2-entry in-order buffer.
module imm_unit #(
    parameter int          XLEN        = 32,
    parameter int unsigned AUTO_DECODE = 1
) (
    input  logic        clk,
    input  logic        reset,
    imm_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_B    = 3'b010,
        FMT_J    = 3'b011,
        FMT_U    = 3'b100,
        FMT_Z    = 3'b101,
        FMT_SH   = 3'b110,
        FMT_NONE = 3'b111
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            ill;
    } entry_t;

    logic [31:0]     ins;
    logic [2:0]      funct3;
    fmt_e            fmt_dec;
    logic            ill_dec;
    logic [XLEN-1:0] imm_dec;
    entry_t          new_entry;

    assign ins    = bus.instr;
    assign funct3 = ins[14:12];

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fmt_dec = FMT_NONE;
        ill_dec = 1'b0;
        if (AUTO_DECODE != 0) begin
            case (ins[6:0])
                7'b0000011, 7'b1100111: fmt_dec = FMT_I;
                7'b0010011: fmt_dec = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                7'b0100011: fmt_dec = FMT_S;
                7'b1100011: fmt_dec = FMT_B;
                7'b1101111: fmt_dec = FMT_J;
                7'b0110111, 7'b0010111: fmt_dec = FMT_U;
                7'b1110011: fmt_dec = ins[14] ? FMT_Z : FMT_I;
                7'b0110011: fmt_dec = FMT_NONE;  // R-type: no immediate, but legal
                default:    ill_dec = 1'b1;
            endcase
        end else begin
            fmt_dec = fmt_e'(bus.immsrc);
            ill_dec = (bus.immsrc == 3'b111);
        end
    end

    always_comb begin
        imm_dec = '0;
        case (fmt_dec)
            FMT_I:  imm_dec = XLEN'($signed(ins[31:20]));
            FMT_S:  imm_dec = XLEN'($signed({ins[31:25], ins[11:7]}));
            FMT_B:  imm_dec = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            FMT_J:  imm_dec = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            FMT_U:  imm_dec = XLEN'($signed({ins[31:12], 12'b0}));
            FMT_Z:  imm_dec = XLEN'(ins[19:15]);
            FMT_SH: imm_dec = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            default: imm_dec = '0;
        endcase
    end

    assign new_entry = '{imm: imm_dec, fmt: fmt_dec, ill: ill_dec};

    entry_t      slot_q [2];
    entry_t      last_q;
    entry_t      head;
    logic        head_q;
    logic        wr_ptr;
    logic [1:0]  count_q, count_d;
    logic [15:0] err_q, err_d;
    logic        in_ready, out_valid, push, pop;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    // With one entry resident the free slot is the other one; empty writes at head.
    assign wr_ptr    = head_q ^ count_q[0];
    assign head      = out_valid ? slot_q[head_q] : last_q;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push && ill_dec && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            last_q  <= '0;
            err_q   <= 16'd0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            if (pop) begin
                head_q <= ~head_q;
                last_q <= slot_q[head_q];
            end
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) slot_q[wr_ptr] <= new_entry;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.immext    = head.imm;
    assign bus.fmt       = head.fmt;
    assign bus.illegal   = head.ill;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_imm_unit.sv
// Bench for imm_unit: three instances (RV32 auto, RV64 auto, RV32 explicit select)
// checked every cycle against a behavioural FIFO model, plus directed literal checks.
module tb_imm_unit;
    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  f;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_unit_if #(.XLEN(32)) if0 ();
    imm_unit_if #(.XLEN(64)) if1 ();
    imm_unit_if #(.XLEN(32)) if2 ();

    imm_unit #(.XLEN(32), .AUTO_DECODE(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    imm_unit #(.XLEN(64), .AUTO_DECODE(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    imm_unit #(.XLEN(32), .AUTO_DECODE(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    logic        tv [3];
    logic        tr [3];
    logic [31:0] ti [3];
    logic [2:0]  ts [3];

    assign if0.in_valid = tv[0]; assign if0.out_ready = tr[0]; assign if0.instr = ti[0]; assign if0.immsrc = ts[0];
    assign if1.in_valid = tv[1]; assign if1.out_ready = tr[1]; assign if1.instr = ti[1]; assign if1.immsrc = ts[1];
    assign if2.in_valid = tv[2]; assign if2.out_ready = tr[2]; assign if2.instr = ti[2]; assign if2.immsrc = ts[2];

    logic        av [3];
    logic        ar [3];
    logic        ail [3];
    logic [63:0] aim [3];
    logic [2:0]  af [3];
    logic [15:0] ae [3];

    assign av[0] = if0.out_valid; assign ar[0] = if0.in_ready; assign ail[0] = if0.illegal;
    assign aim[0] = {32'h0, if0.immext}; assign af[0] = if0.fmt; assign ae[0] = if0.err_count;
    assign av[1] = if1.out_valid; assign ar[1] = if1.in_ready; assign ail[1] = if1.illegal;
    assign aim[1] = if1.immext; assign af[1] = if1.fmt; assign ae[1] = if1.err_count;
    assign av[2] = if2.out_valid; assign ar[2] = if2.in_ready; assign ail[2] = if2.illegal;
    assign aim[2] = {32'h0, if2.immext}; assign af[2] = if2.fmt; assign ae[2] = if2.err_count;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Straight from the format table: pick the format, then extend with integer arithmetic.
    function automatic exp_t model_imm(input logic [31:0] ins, input logic [2:0] src,
                                       input int xlen, input bit auto_dec);
        exp_t   e;
        longint v;
        int     f;
        e.ill = 1'b0;
        f     = 7;
        if (auto_dec) begin
            case (ins[6:0])
                7'b0000011, 7'b1100111: f = 0;
                7'b0010011: f = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 6 : 0;
                7'b0100011: f = 1;
                7'b1100011: f = 2;
                7'b1101111: f = 3;
                7'b0110111, 7'b0010111: f = 4;
                7'b1110011: f = ins[14] ? 5 : 0;
                7'b0110011: f = 7;
                default: begin f = 7; e.ill = 1'b1; end
            endcase
        end else begin
            f     = int'(src);
            e.ill = (src == 3'b111);
        end
        case (f)
            0: v = longint'($signed(ins[31:20]));
            1: v = longint'($signed({ins[31:25], ins[11:7]}));
            2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            4: v = longint'($signed(ins[31:12])) * 4096;
            5: v = longint'(ins[19:15]);
            6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        e.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
        e.f   = f[2:0];
        return e;
    endfunction

    exp_t mbuf [3][2];
    exp_t mlast [3];
    int   mcnt [3];
    int   merr [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            mcnt[d]  = 0;
            merr[d]  = 0;
            mlast[d] = '0;
        end
    end

    // Model update at each edge, then compare every output of every instance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                mcnt[d]  = 0;
                merr[d]  = 0;
                mlast[d] = '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                bit   pu, po;
                exp_t e;
                pu = tv[d] && (mcnt[d] < 2);
                po = (mcnt[d] > 0) && tr[d];
                e  = model_imm(ti[d], ts[d], (d == 1) ? 64 : 32, d != 2);
                if (po) begin
                    mlast[d]   = mbuf[d][0];
                    mbuf[d][0] = mbuf[d][1];
                    mcnt[d]--;
                end
                if (pu) begin
                    mbuf[d][mcnt[d]] = e;
                    mcnt[d]++;
                    if (e.ill && merr[d] < 65535) merr[d]++;
                end
            end
            #1;
            if (reset) begin
                for (int d = 0; d < 3; d++) begin
                    exp_t h;
                    h = (mcnt[d] > 0) ? mbuf[d][0] : mlast[d];
                    check("out_valid", d, 64'(av[d]), 64'(mcnt[d] > 0));
                    check("in_ready",  d, 64'(ar[d]), 64'(mcnt[d] < 2));
                    check("immext",    d, aim[d], h.imm);
                    check("fmt",       d, 64'(af[d]), 64'(h.f));
                    check("illegal",   d, 64'(ail[d]), 64'(h.ill));
                    check("err_count", d, 64'(ae[d]), 64'(merr[d]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t p;
        p = model_imm(32'hFFF00093, 3'd0, 32, 1'b1); check("pin addi", 0, p.imm, 64'hFFFF_FFFF);
        p = model_imm(32'h02109093, 3'd0, 64, 1'b1); check("pin slli64", 1, {p.imm[60:0], p.f}, {61'h21, 3'b110});
        p = model_imm(32'h80000037, 3'd0, 64, 1'b1); check("pin lui64", 1, p.imm, 64'hFFFF_FFFF_8000_0000);
        p = model_imm(32'hFE000EE3, 3'd0, 32, 1'b1); check("pin beq", 0, p.imm, 64'hFFFF_FFFC);
        p = model_imm(32'h00000000, 3'd0, 32, 1'b1); check("pin zero ill", 0, 64'(p.ill), 64'd1);

        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            tv[d] = 1'b0; tr[d] = 1'b1; ti[d] = 32'h0; ts[d] = 3'd0;
        end
        repeat (2) @(negedge clk);
        check("rst out_valid", 0, 64'(av[0]), 64'd0);
        check("rst in_ready",  0, 64'(ar[0]), 64'd1);
        check("rst immext",    0, aim[0], 64'd0);
        check("rst fmt",       0, 64'(af[0]), 64'd0);
        check("rst illegal",   0, 64'(ail[0]), 64'd0);
        check("rst err_count", 0, 64'(ae[0]), 64'd0);
        reset = 1'b1;

        // Directed decode vectors on all three instances.
        tv[0] = 1'b1; ti[0] = 32'hFFF00093;
        tv[1] = 1'b1; ti[1] = 32'h02109093;
        tv[2] = 1'b1; ti[2] = 32'hFFF00093; ts[2] = 3'b111;
        @(negedge clk);
        check("addi valid", 0, 64'(av[0]), 64'd1);
        check("addi imm",   0, aim[0], 64'hFFFF_FFFF);
        check("addi fmt",   0, 64'(af[0]), 64'd0);
        check("addi ill",   0, 64'(ail[0]), 64'd0);
        check("slli imm",   1, aim[1], 64'h21);
        check("slli fmt",   1, 64'(af[1]), 64'd6);
        check("sel111 ill", 2, 64'(ail[2]), 64'd1);
        check("sel111 imm", 2, aim[2], 64'd0);
        check("sel111 err", 2, 64'(ae[2]), 64'd1);
        ti[0] = 32'h123450B7; ti[1] = 32'h80000037; ti[2] = 32'h80000037; ts[2] = 3'b100;
        @(negedge clk);
        check("lui imm",    0, aim[0], 64'h1234_5000);
        check("lui fmt",    0, 64'(af[0]), 64'd4);
        check("lui64 imm",  1, aim[1], 64'hFFFF_FFFF_8000_0000);
        check("selU imm",   2, aim[2], 64'h8000_0000);
        check("selU ill",   2, 64'(ail[2]), 64'd0);
        tv[1] = 1'b0; tv[2] = 1'b0; ti[0] = 32'h0040006F;
        @(negedge clk);
        check("jal imm", 0, aim[0], 64'h4);
        check("jal fmt", 0, 64'(af[0]), 64'd3);
        ti[0] = 32'hFE000EE3;
        @(negedge clk);
        check("beq imm", 0, aim[0], 64'hFFFF_FFFC);
        check("beq fmt", 0, 64'(af[0]), 64'd2);
        tv[0] = 1'b0;
        @(negedge clk);
        check("empty valid", 0, 64'(av[0]), 64'd0);
        check("empty hold",  0, aim[0], 64'hFFFF_FFFC);

        // Backpressure: three offered while the consumer stalls.
        tr[0] = 1'b0; tv[0] = 1'b1; ti[0] = 32'h00100093;
        @(negedge clk);
        check("bp1 imm", 0, aim[0], 64'h1);
        check("bp1 rdy", 0, 64'(ar[0]), 64'd1);
        ti[0] = 32'h00200093;
        @(negedge clk);
        check("bp2 rdy", 0, 64'(ar[0]), 64'd0);
        ti[0] = 32'h00300093;
        @(negedge clk);
        check("bp3 rdy",    0, 64'(ar[0]), 64'd0);
        check("bp3 stable", 0, aim[0], 64'h1);
        tr[0] = 1'b1;
        @(negedge clk);
        check("bp drain2 imm", 0, aim[0], 64'h2);
        check("bp drain2 rdy", 0, 64'(ar[0]), 64'd1);
        @(negedge clk);
        check("bp drain3 imm", 0, aim[0], 64'h3);
        tv[0] = 1'b0;
        @(negedge clk);
        check("bp done", 0, 64'(av[0]), 64'd0);

        // Two illegal instructions.
        tv[0] = 1'b1; ti[0] = 32'h0;
        @(negedge clk);
        check("ill1 err", 0, 64'(ae[0]), 64'd1);
        @(negedge clk);
        tv[0] = 1'b0;
        check("ill2 ill", 0, 64'(ail[0]), 64'd1);
        check("ill2 imm", 0, aim[0], 64'd0);
        check("ill2 fmt", 0, 64'(af[0]), 64'd7);
        check("ill2 err", 0, 64'(ae[0]), 64'd2);

        // Reset between edges with two entries buffered.
        tr[0] = 1'b0; tv[0] = 1'b1; ti[0] = 32'h00100093;
        repeat (2) @(negedge clk);
        tv[0] = 1'b0;
        check("pre-rst full", 0, 64'(ar[0]), 64'd0);
        #2 reset = 1'b0;
        #1;
        check("mid-rst valid", 0, 64'(av[0]), 64'd0);
        check("mid-rst rdy",   0, 64'(ar[0]), 64'd1);
        check("mid-rst err",   0, 64'(ae[0]), 64'd0);
        check("mid-rst imm",   0, aim[0], 64'd0);
        @(negedge clk);
        reset = 1'b1; tr[0] = 1'b1; tv[0] = 1'b1; ti[0] = 32'hFFF00093;
        @(negedge clk);
        tv[0] = 1'b0;
        check("post-rst valid", 0, 64'(av[0]), 64'd1);
        check("post-rst imm",   0, aim[0], 64'hFFFF_FFFF);

        // Saturate the illegal counter and push past it.
        tv[0] = 1'b1; ti[0] = 32'h0;
        repeat (65540) @(negedge clk);
        tv[0] = 1'b0;
        @(negedge clk);
        check("sat err", 0, 64'(ae[0]), 64'hFFFF);
        check("sat ill", 0, 64'(ail[0]), 64'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_unit.md
# imm_unit

Parametrised, buffered immediate generator for the RV32/RV64 decode stage. Accepts one raw 32-bit instruction per handshake, derives its immediate format (from the opcode or from an explicit select), sign/zero-extends the immediate to XLEN, and delivers the result through a 2-entry output buffer with valid/ready flow control. It also flags instructions that carry no legal immediate format and keeps a saturating count of them for debug.

## Interface
- XLEN, 32: result width; legal values 32 or 64.
- AUTO_DECODE, 1: 1 = format derived from opcode and `immsrc` ignored; 0 = format taken from `immsrc`.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  buffer can accept; equals (count < 2).
- instr  input  32  raw instruction word.
- immsrc  input  3  format select when AUTO_DECODE=0.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- immext  output  XLEN  extended immediate of head entry.
- fmt  output  3  format code of head entry.
- illegal  output  1  head entry had no legal format.
- err_count  output  16  saturating count of accepted illegal entries.

## Operation
- Format codes (`fmt`/`immsrc`):
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 are copies of instr[31].
  - 101 Z: zext(instr[19:15]) (CSR uimm).
  - 110 SH: zext(instr[25:20]) for XLEN=64, zext(instr[24:20]) for XLEN=32.
  - 111 NONE: immext = 0.
- AUTO_DECODE=1 map on instr[6:0]:
  - 0000011, 1100111 → I.
  - 0010011 → SH if funct3 ∈ {001, 101}, else I.
  - 0100011 → S. 1100011 → B. 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011 → Z if instr[14]=1, else I.
  - 0110011 → NONE, illegal=0.
  - Any other opcode → NONE, illegal=1.
- AUTO_DECODE=0: `immsrc` is used directly; 111 gives NONE with illegal=1.
- Extension is combinational on the input side. The computed immext/fmt/illegal triple is written into the buffer on accept (in_valid && in_ready).
- Buffer: 2-entry FIFO, in-order delivery. The head entry drives the outputs.
- err_count increments by 1 on each accept with illegal=1 and holds at 0xFFFF.

## Timing
- Reset (async assert, synchronous release on clk): count=0, out_valid=0, immext=0, fmt=000, illegal=0, err_count=0, in_ready=1.
- Latency: an instruction accepted at edge N appears on out_valid/immext after edge N when the buffer was empty, i.e. 1 cycle.
- Throughput: 1 per cycle while out_ready=1.
- Pop occurs when out_valid && out_ready.
- While out_valid=1 and out_ready=0, immext/fmt/illegal are held stable.
- Push and pop in the same cycle with count=1: count stays 1, and the new entry becomes head.
- count=2: in_ready=0, so no push occurs. A pop that cycle leaves count=1, and in_ready rises in the next cycle. in_ready has no combinational dependence on out_ready.
- When the buffer is empty, immext/fmt/illegal hold their last popped values.
- Reset asserted mid-operation: all entries discarded; outputs return to reset values immediately, without waiting for clk.

## Test plan
- XLEN=32, AUTO: push 0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, immext=0xFFFFFFFF, fmt=000, illegal=0.
- XLEN=32, AUTO: push 0x123450B7 (lui), then 0x0040006F (jal +4), then 0xFE000EE3 (beq −4), out_ready=1 → in order: 0x12345000/U, 0x00000004/J, 0xFFFFFFFC/B.
- XLEN=64, AUTO: push 0x02109093 (slli x1,x1,33) → immext=0x0000000000000021, fmt=110. Push lui 0x80000037 → immext=0xFFFFFFFF80000000.
- Backpressure: out_ready=0, push 3 in consecutive cycles → in_ready=0 after the 2nd accept and the 3rd is held off. Raise out_ready → entries 1, 2, 3 delivered in order; immext stable while stalled.
- Illegal: push 0x00000000 twice → illegal=1, immext=0, err_count=2. With AUTO_DECODE=0, immsrc=111 → illegal=1. Preset 0xFFFF plus one more illegal → err_count stays 0xFFFF.
- Reset mid-operation: 2 entries buffered, drive reset low between edges → out_valid=0, in_ready=1, err_count=0 immediately. After release, the first push appears with 1-cycle latency.
